adc_power_sequencer: RTL and testbench

//   Brings the ADC front-end up and down in a fixed order: rails, ADC reset release, then a burst of init

---
 rtl/adc_power_sequencer.sv | 174 +++++++++++++++++
 tb/tb_adc_power_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_power_sequencer.sv
// rtl/adc_power_sequencer.sv - ADC front-end power-up/down sequencer with AXIS init burst
module adc_power_sequencer #(
   parameter int DELAY_W    = 16,
   parameter int INIT_WORDS = 2,
   parameter int TIMEOUT    = 1024
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   input  logic                    en_req,
   input  logic [DELAY_W-1:0]      step_delay,
   input  logic [32*INIT_WORDS-1:0] init_cmd,
   output logic                    pwr_en,
   output logic                    ref_en,
   output logic                    io_en,
   output logic                    diffamp_en,
   output logic                    opamp_en,
   output logic                    adc_resetn,
   output logic [31:0]             m_axis_tdata,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic                    ready,
   output logic                    busy,
   output logic                    fault
);

   localparam int BEAT_W = (INIT_WORDS > 1) ? $clog2(INIT_WORDS) : 1;
   localparam int TMO_W  = $clog2(TIMEOUT + 1);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(INIT_WORDS - 1);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_OFF,
      S_UP,
      S_INIT,
      S_ON,
      S_DOWN,
      S_FAULT
   } state_t;

   state_t             state;
   logic [DELAY_W-1:0] d_lat;
   logic [DELAY_W-1:0] cnt;
   logic [2:0]         k;
   // rails[0]=pwr .. rails[4]=opamp, rails[5]=adc_resetn; k is the highest asserted step
   logic [5:0]         rails;
   logic [BEAT_W-1:0]  beat;
   logic [BEAT_W-1:0]  beat_next;
   logic [31:0]        word_next;
   logic [TMO_W-1:0]   tmo_cnt;

   assign pwr_en     = rails[0];
   assign ref_en     = rails[1];
   assign io_en      = rails[2];
   assign diffamp_en = rails[3];
   assign opamp_en   = rails[4];
   assign adc_resetn = rails[5];

   assign beat_next = beat + BEAT_W'(1);
   assign word_next = init_cmd[{beat_next, 5'b00000} +: 32];

   // Sequencer FSM: ramps rails up, streams init words, ramps down in reverse
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state         <= S_OFF;
         d_lat         <= '0;
         cnt           <= '0;
         k             <= '0;
         rails         <= '0;
         beat          <= '0;
         tmo_cnt       <= '0;
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         ready         <= 1'b0;
         busy          <= 1'b0;
         fault         <= 1'b0;
      end else begin
         case (state)
            S_OFF: begin
               if (en_req && !fault) begin
                  d_lat <= step_delay;
                  rails <= 6'b000001;
                  k     <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= S_UP;
               end
            end
            S_UP: begin
               if (!en_req) begin
                  // abort: unwind only what is already up, first drop on the next edge
                  cnt   <= d_lat;
                  state <= S_DOWN;
               end else if (cnt == d_lat) begin
                  cnt <= '0;
                  if (k == 3'd5) begin
                     m_axis_tvalid <= 1'b1;
                     m_axis_tdata  <= init_cmd[31:0];
                     beat          <= '0;
                     tmo_cnt       <= '0;
                     state         <= S_INIT;
                  end else begin
                     k                <= k + 3'd1;
                     rails[k + 3'd1]  <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + DELAY_W'(1);
               end
            end
            S_INIT: begin
               if (m_axis_tready) begin
                  tmo_cnt <= '0;
                  if (!en_req) begin
                     // word handed over, but power-down wins over finishing the burst
                     m_axis_tvalid <= 1'b0;
                     m_axis_tdata  <= '0;
                     cnt           <= d_lat;
                     state         <= S_DOWN;
                  end else if (beat == LAST_BEAT) begin
                     m_axis_tvalid <= 1'b0;
                     m_axis_tdata  <= '0;
                     ready         <= 1'b1;
                     busy          <= 1'b0;
                     state         <= S_ON;
                  end else begin
                     beat         <= beat_next;
                     m_axis_tdata <= word_next;
                  end
               end else if (tmo_cnt == TMO_LAST) begin
                  m_axis_tvalid <= 1'b0;
                  m_axis_tdata  <= '0;
                  fault         <= 1'b1;
                  cnt           <= d_lat;
                  state         <= S_DOWN;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
            end
            S_ON: begin
               if (!en_req) begin
                  ready <= 1'b0;
                  busy  <= 1'b1;
                  cnt   <= d_lat;
                  state <= S_DOWN;
               end
            end
            S_DOWN: begin
               if (cnt == d_lat) begin
                  rails[k] <= 1'b0;
                  cnt      <= '0;
                  if (k == 3'd0) begin
                     busy  <= 1'b0;
                     state <= fault ? S_FAULT : S_OFF;
                  end else begin
                     k <= k - 3'd1;
                  end
               end else begin
                  cnt <= cnt + DELAY_W'(1);
               end
            end
            S_FAULT: begin
               // fault only clears once the requester withdraws en_req
               if (!en_req) begin
                  fault <= 1'b0;
                  state <= S_OFF;
               end
            end
            default: begin
               state <= S_OFF;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adc_power_sequencer.sv
// tb/tb_adc_power_sequencer.sv - scoreboard bench for adc_power_sequencer
module tb_adc_power_sequencer;

   logic        aclk;
   logic        aresetn;
   logic        en_req;
   logic [15:0] step_delay;
   logic [63:0] init_cmd;
   logic        pwr_en, ref_en, io_en, diffamp_en, opamp_en, adc_resetn;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        ready, busy, fault;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic mon_en = 1'b0;
   logic [31:0] prev_rails = '0;

   typedef struct {
      int          cyc;
      logic [31:0] val;
   } exp_t;

   exp_t rail_q[$];
   exp_t beat_q[$];

   adc_power_sequencer #(
      .DELAY_W   (16),
      .INIT_WORDS(2),
      .TIMEOUT   (8)
   ) dut (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .en_req       (en_req),
      .step_delay   (step_delay),
      .init_cmd     (init_cmd),
      .pwr_en       (pwr_en),
      .ref_en       (ref_en),
      .io_en        (io_en),
      .diffamp_en   (diffamp_en),
      .opamp_en     (opamp_en),
      .adc_resetn   (adc_resetn),
      .m_axis_tdata (m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .ready        (ready),
      .busy         (busy),
      .fault        (fault)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   always @(posedge aclk) cyc <= cyc + 1;

   // scoreboard: rail edges and AXIS handshakes are popped as the DUT produces them
   always @(negedge aclk) begin
      logic [31:0] cur;
      exp_t x;
      cur = {26'd0, adc_resetn, opamp_en, diffamp_en, io_en, ref_en, pwr_en};
      if (mon_en && cur !== prev_rails) begin
         checks++;
         if (rail_q.size() == 0) begin
            errors++;
            $display("FAIL rail_unexpected cyc %0d got %b", cyc, cur[5:0]);
         end else begin
            x = rail_q.pop_front();
            if (cur !== x.val || cyc != x.cyc) begin
               errors++;
               $display("FAIL rail_event got %b at cyc %0d, want %b at cyc %0d",
                        cur[5:0], cyc, x.val[5:0], x.cyc);
            end
         end
      end
      prev_rails = cur;
      if (mon_en && m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
         checks++;
         if (beat_q.size() == 0) begin
            errors++;
            $display("FAIL beat_unexpected cyc %0d got %h", cyc, m_axis_tdata);
         end else begin
            x = beat_q.pop_front();
            if (m_axis_tdata !== x.val || cyc != x.cyc) begin
               errors++;
               $display("FAIL beat got %h at cyc %0d, want %h at cyc %0d",
                        m_axis_tdata, cyc, x.val, x.cyc);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at cyc %0d", cyc);
      $fatal(1);
   end

   // return just after posedge n, where inputs are driven
   task automatic to_drive(input int n);
      while (cyc < n) begin
         @(posedge aclk);
         #1;
      end
   endtask

   // return on the negedge that follows posedge n
   task automatic to_sample(input int n);
      do @(negedge aclk); while (cyc < n);
   endtask

   task automatic push_up(input int e0, input int d, input int n);
      exp_t x;
      for (int i = 0; i < n; i++) begin
         x.cyc = e0 + i * (d + 1);
         x.val = (32'd1 << (i + 1)) - 32'd1;
         rail_q.push_back(x);
      end
   endtask

   task automatic push_down(input int e1, input int d, input int top);
      exp_t x;
      for (int j = 0; j <= top; j++) begin
         x.cyc = e1 + j * (d + 1);
         x.val = (32'd1 << (top - j)) - 32'd1;
         rail_q.push_back(x);
      end
   endtask

   task automatic push_beat(input int c, input logic [31:0] w);
      exp_t x;
      x.cyc = c;
      x.val = w;
      beat_q.push_back(x);
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      en_req = 1'b0;
      step_delay = 16'd0;
      init_cmd = '0;
      m_axis_tready = 1'b0;
      to_sample(3);
      checks++; if (pwr_en !== 1'b0) begin errors++; $display("FAIL reset_pwr got %b want 0", pwr_en); end
      checks++; if (adc_resetn !== 1'b0) begin errors++; $display("FAIL reset_adc_resetn got %b want 0", adc_resetn); end
      checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", m_axis_tvalid); end
      checks++; if (m_axis_tdata !== 32'd0) begin errors++; $display("FAIL reset_tdata got %h want 0", m_axis_tdata); end
      checks++; if ({ready, busy, fault} !== 3'b000) begin errors++; $display("FAIL reset_status got %b want 000", {ready, busy, fault}); end
      to_drive(4);
      aresetn = 1'b1;
      mon_en = 1'b1;
      to_sample(6);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
   endtask

   task automatic test_power_up();
      int e0;
      logic [31:0] w0, w1;
      w0 = 32'hA1A1_0000;
      w1 = 32'hB2B2_0001;
      step_delay = 16'd2;
      init_cmd = {w1, w0};
      m_axis_tready = 1'b1;
      @(posedge aclk); #1;
      e0 = cyc + 1;
      push_up(e0, 2, 6);
      push_beat(e0 + 18, w0);
      push_beat(e0 + 19, w1);
      en_req = 1'b1;
      to_drive(e0);
      step_delay = 16'd5;
      to_sample(e0 + 19);
      checks++; if (ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL up_status_last_beat got r%b b%b want r0 b1", ready, busy); end
      to_sample(e0 + 20);
      checks++; if (ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL up_ready got r%b b%b want r1 b0", ready, busy); end
      checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL up_tvalid_after got %b want 0", m_axis_tvalid); end
      checks++; if (rail_q.size() != 0 || beat_q.size() != 0) begin errors++; $display("FAIL up_drain rails %0d beats %0d want 0 0", rail_q.size(), beat_q.size()); end
   endtask

   task automatic test_power_down();
      int e;
      @(posedge aclk); #1;
      e = cyc + 1;
      push_down(e + 1, 2, 5);
      en_req = 1'b0;
      to_sample(e);
      checks++; if (ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL down_entry got r%b b%b want r0 b1", ready, busy); end
      checks++; if (adc_resetn !== 1'b1) begin errors++; $display("FAIL down_entry_adc got %b want 1", adc_resetn); end
      to_sample(e + 15);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL down_busy got %b want 1", busy); end
      to_sample(e + 16);
      checks++; if (busy !== 1'b0 || pwr_en !== 1'b0) begin errors++; $display("FAIL down_done got b%b p%b want b0 p0", busy, pwr_en); end
      to_sample(e + 18);
      checks++; if (rail_q.size() != 0) begin errors++; $display("FAIL down_drain got %0d want 0", rail_q.size()); end
   endtask

   task automatic test_stall();
      int e0, e;
      logic [31:0] w0, w1;
      w0 = 32'hC3C3_1111;
      w1 = 32'hD4D4_2222;
      step_delay = 16'd2;
      init_cmd = {w1, w0};
      m_axis_tready = 1'b0;
      @(posedge aclk); #1;
      e0 = cyc + 1;
      push_up(e0, 2, 6);
      push_beat(e0 + 23, w0);
      push_beat(e0 + 24, w1);
      en_req = 1'b1;
      to_sample(e0 + 20);
      checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== w0) begin errors++; $display("FAIL stall_hold got v%b %h want v1 %h", m_axis_tvalid, m_axis_tdata, w0); end
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL stall_fault got %b want 0", fault); end
      to_drive(e0 + 23);
      m_axis_tready = 1'b1;
      to_sample(e0 + 25);
      checks++; if (ready !== 1'b1 || fault !== 1'b0) begin errors++; $display("FAIL stall_ready got r%b f%b want r1 f0", ready, fault); end
      to_drive(e0 + 26);
      e = e0 + 27;
      push_down(e + 1, 2, 5);
      en_req = 1'b0;
      to_sample(e + 17);
      checks++; if (busy !== 1'b0 || rail_q.size() != 0 || beat_q.size() != 0) begin errors++; $display("FAIL stall_end busy %b rails %0d beats %0d want 0 0 0", busy, rail_q.size(), beat_q.size()); end
   endtask

   task automatic test_timeout();
      int e0;
      step_delay = 16'd2;
      init_cmd = {32'hEEEE_0001, 32'hEEEE_0000};
      m_axis_tready = 1'b0;
      @(posedge aclk); #1;
      e0 = cyc + 1;
      push_up(e0, 2, 6);
      push_down(e0 + 27, 2, 5);
      en_req = 1'b1;
      to_sample(e0 + 25);
      checks++; if (m_axis_tvalid !== 1'b1 || fault !== 1'b0) begin errors++; $display("FAIL tmo_before got v%b f%b want v1 f0", m_axis_tvalid, fault); end
      to_sample(e0 + 26);
      checks++; if (m_axis_tvalid !== 1'b0 || fault !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL tmo_hit got v%b f%b b%b want v0 f1 b1", m_axis_tvalid, fault, busy); end
      to_sample(e0 + 45);
      checks++; if (fault !== 1'b1 || busy !== 1'b0 || ready !== 1'b0 || pwr_en !== 1'b0) begin errors++; $display("FAIL tmo_fault_state got f%b b%b r%b p%b want f1 b0 r0 p0", fault, busy, ready, pwr_en); end
      to_drive(e0 + 46);
      en_req = 1'b0;
      to_sample(e0 + 47);
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL tmo_clear got %b want 0", fault); end
      checks++; if (rail_q.size() != 0 || beat_q.size() != 0) begin errors++; $display("FAIL tmo_drain rails %0d beats %0d want 0 0", rail_q.size(), beat_q.size()); end
   endtask

   task automatic test_last_abort();
      int e0;
      logic [31:0] w0, w1;
      w0 = 32'h1234_5678;
      w1 = 32'h9ABC_DEF0;
      step_delay = 16'd1;
      init_cmd = {w1, w0};
      m_axis_tready = 1'b1;
      @(posedge aclk); #1;
      e0 = cyc + 1;
      push_up(e0, 1, 6);
      push_beat(e0 + 12, w0);
      push_beat(e0 + 13, w1);
      push_down(e0 + 15, 1, 5);
      en_req = 1'b1;
      to_drive(e0 + 13);
      en_req = 1'b0;
      to_sample(e0 + 14);
      checks++; if (ready !== 1'b0 || busy !== 1'b1 || m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL abort_last got r%b b%b v%b want r0 b1 v0", ready, busy, m_axis_tvalid); end
      to_sample(e0 + 27);
      checks++; if (busy !== 1'b0 || rail_q.size() != 0 || beat_q.size() != 0) begin errors++; $display("FAIL abort_drain busy %b rails %0d beats %0d want 0 0 0", busy, rail_q.size(), beat_q.size()); end
   endtask

   task automatic test_up_abort();
      int e0;
      step_delay = 16'd3;
      m_axis_tready = 1'b1;
      @(posedge aclk); #1;
      e0 = cyc + 1;
      push_up(e0, 3, 3);
      push_down(e0 + 10, 3, 2);
      en_req = 1'b1;
      to_drive(e0 + 8);
      en_req = 1'b0;
      to_sample(e0 + 9);
      checks++; if (busy !== 1'b1 || io_en !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL upabort_entry got b%b io%b r%b want b1 io1 r0", busy, io_en, ready); end
      to_sample(e0 + 22);
      checks++; if (busy !== 1'b0 || {adc_resetn, opamp_en, diffamp_en} !== 3'b000) begin errors++; $display("FAIL upabort_end got b%b hi%b want b0 hi000", busy, {adc_resetn, opamp_en, diffamp_en}); end
      checks++; if (rail_q.size() != 0) begin errors++; $display("FAIL upabort_drain got %0d want 0", rail_q.size()); end
   endtask

   task automatic test_async_reset();
      int e0, e1;
      logic [31:0] w0, w1;
      w0 = 32'h5555_AAAA;
      w1 = 32'h6666_BBBB;
      step_delay = 16'd1;
      init_cmd = {w1, w0};
      m_axis_tready = 1'b0;
      @(posedge aclk); #1;
      e0 = cyc + 1;
      push_up(e0, 1, 6);
      en_req = 1'b1;
      to_drive(e0 + 14);
      checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL arst_pre_tvalid got %b want 1", m_axis_tvalid); end
      mon_en = 1'b0;
      aresetn = 1'b0;
      #1;
      checks++; if ({adc_resetn, opamp_en, diffamp_en, io_en, ref_en, pwr_en} !== 6'd0) begin errors++; $display("FAIL arst_rails got %b want 000000", {adc_resetn, opamp_en, diffamp_en, io_en, ref_en, pwr_en}); end
      checks++; if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 32'd0 || busy !== 1'b0) begin errors++; $display("FAIL arst_axis got v%b %h b%b want v0 0 b0", m_axis_tvalid, m_axis_tdata, busy); end
      checks++; if (rail_q.size() != 0) begin errors++; $display("FAIL arst_drain got %0d want 0", rail_q.size()); end
      step_delay = 16'd0;
      m_axis_tready = 1'b1;
      to_drive(e0 + 16);
      aresetn = 1'b1;
      mon_en = 1'b1;
      e1 = e0 + 17;
      push_up(e1, 0, 6);
      push_beat(e1 + 6, w0);
      push_beat(e1 + 7, w1);
      to_sample(e1 + 8);
      checks++; if (ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL arst_restart got r%b b%b want r1 b0", ready, busy); end
      checks++; if (rail_q.size() != 0 || beat_q.size() != 0) begin errors++; $display("FAIL arst_restart_drain rails %0d beats %0d want 0 0", rail_q.size(), beat_q.size()); end
   endtask

   initial begin
      test_reset();
      test_power_up();
      test_power_down();
      test_stall();
      test_timeout();
      test_last_abort();
      test_up_abort();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
